// File: rtl/stream_mux_pkg.sv
// Shared definitions for the streaming multiplexer: FSM encodings, arbitration
// mode constants and a constant-evaluable log2 helper.
package stream_mux_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Ceiling log2, never below 1 so a select field always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search upward from a pointer (wrapping),
// or fixed priority where the lowest requesting index wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int ARB_MODE  = ARB_RR,
  parameter int SEL_WIDTH = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]  i_req,
  input  logic [SEL_WIDTH-1:0] i_ptr,
  output logic [CHANNELS-1:0]  o_grant,
  output logic [SEL_WIDTH-1:0] o_idx,
  output logic                 o_found
);

  int                   base;
  int                   cand;
  logic [SEL_WIDTH-1:0] cand_idx;

  always_comb begin
    o_grant  = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    base     = (ARB_MODE == ARB_FIXED) ? 0 : int'(i_ptr);
    for (int i = 0; i < CHANNELS; i++) begin
      cand = base + i;
      if (cand >= CHANNELS) begin
        cand = cand - CHANNELS;
      end
      cand_idx = cand[SEL_WIDTH-1:0];
      if (!o_found && i_req[cand_idx]) begin
        o_found = 1'b1;
        o_idx   = cand_idx;
      end
    end
    if (o_found) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel framed stream multiplexer with arbitration, packet lock and a
// registered, full-throughput output stage with valid/ready handshake.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS   = 8,
  parameter  int DATA_WIDTH = 8,
  parameter  int ARB_MODE   = ARB_RR,
  localparam int SEL_WIDTH  = clog2(CHANNELS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]            i_valid,
  input  logic [CHANNELS-1:0]            i_last,
  input  logic [CHANNELS-1:0]            i_mask,
  output logic [CHANNELS-1:0]            o_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_valid,
  output logic                           o_last,
  output logic [SEL_WIDTH-1:0]           o_sel,
  input  logic                           i_ready
);

  logic [0:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  grant_q, grant_d;
  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;

  logic                  load;
  logic                  xfer;
  logic                  xfer_last;
  logic [CHANNELS-1:0]   ready;
  logic [CHANNELS-1:0]   req;
  logic [CHANNELS-1:0]   arb_grant;
  logic [SEL_WIDTH-1:0]  arb_idx;
  logic                  arb_found;
  logic [SEL_WIDTH-1:0]  sel_idx;
  logic [DATA_WIDTH-1:0] data_arr [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign data_arr[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req = i_valid & i_mask;

  rr_arbiter #(
    .CHANNELS  (CHANNELS),
    .ARB_MODE  (ARB_MODE),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (ptr_q),
    .o_grant (arb_grant),
    .o_idx   (arb_idx),
    .o_found (arb_found)
  );

  // Channel select and ready generation; a locked packet bypasses the arbiter.
  always_comb begin
    load    = !valid_q || i_ready;
    ready   = '0;
    sel_idx = arb_idx;
    if (state_q == ST_LOCK) begin
      sel_idx        = grant_q;
      ready[grant_q] = load;
    end else if (arb_found && load) begin
      ready = arb_grant;
    end
    if (!i_rst_n) begin
      ready = '0;
    end
    xfer      = |(ready & i_valid);
    xfer_last = i_last[sel_idx];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    sel_d   = sel_q;

    if (load) begin
      valid_d = xfer;
      if (xfer) begin
        data_d = data_arr[sel_idx];
        last_d = xfer_last;
        sel_d  = sel_idx;
      end
    end

    if (xfer) begin
      if (xfer_last) begin
        state_d = ST_IDLE;
        ptr_d   = (sel_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0 : sel_idx + SEL_WIDTH'(1);
      end else if (state_q == ST_IDLE) begin
        state_d = ST_LOCK;
        grant_d = sel_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign o_ready = ready;
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_sel   = sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance and a fixed-priority
// instance, each stepped through hand-computed sequences.
module tb_stream_mux_rr;

  logic        clk;
  int          checks;
  int          errors;

  logic        rst_n_a, rst_n_b;
  logic [63:0] data_a, data_b;
  logic [7:0]  valid_a, valid_b, last_a, last_b, mask_a, mask_b;
  logic [7:0]  ordy_a, ordy_b;
  logic [7:0]  odata_a, odata_b;
  logic        ovalid_a, ovalid_b, olast_a, olast_b;
  logic [2:0]  osel_a, osel_b;
  logic        ready_a, ready_b;

  logic [7:0]  acc[$];

  stream_mux_rr #(.CHANNELS(8), .DATA_WIDTH(8), .ARB_MODE(0)) dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n_a),
    .i_data  (data_a),
    .i_valid (valid_a),
    .i_last  (last_a),
    .i_mask  (mask_a),
    .o_ready (ordy_a),
    .o_data  (odata_a),
    .o_valid (ovalid_a),
    .o_last  (olast_a),
    .o_sel   (osel_a),
    .i_ready (ready_a)
  );

  stream_mux_rr #(.CHANNELS(8), .DATA_WIDTH(8), .ARB_MODE(1)) dut_fp (
    .i_clk   (clk),
    .i_rst_n (rst_n_b),
    .i_data  (data_b),
    .i_valid (valid_b),
    .i_last  (last_b),
    .i_mask  (mask_b),
    .o_ready (ordy_b),
    .o_data  (odata_b),
    .o_valid (ovalid_b),
    .o_last  (olast_b),
    .o_sel   (osel_b),
    .i_ready (ready_b)
  );

  always #5 clk = ~clk;

  // Words accepted downstream from channel 1, for the lock/backpressure sequence.
  always @(posedge clk) begin
    if (rst_n_a && ovalid_a && ready_a && osel_a == 3'd1) begin
      acc.push_back(odata_a);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int g;
    int cnt2;
    int cnt5;
    logic [7:0] exp_d;

    checks = 0;
    errors = 0;
    clk    = 1'b0;
    cnt2   = 0;
    cnt5   = 0;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    valid_a = 8'hFF;
    last_a  = 8'hFF;
    mask_a  = 8'hFF;
    ready_a = 1'b1;
    for (int k = 0; k < 8; k++) data_a[k*8 +: 8] = 8'(8'h10 + k);
    valid_b = 8'h00;
    last_b  = 8'h00;
    mask_b  = 8'hFF;
    ready_b = 1'b1;
    data_b  = '0;

    // Reset held with every channel requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("reset cycle %0d: valid=%0b ready=%02h sel=%0d", i, ovalid_a, ordy_a, osel_a);
      check("rst_valid", ovalid_a, 0);
      check("rst_ready", ordy_a, 0);
      check("rst_sel", osel_a, 0);
    end

    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    #1;
    check("first_ready", ordy_a, 32'h01);
    tick();
    $display("first grant: sel=%0d data=%02h", osel_a, odata_a);
    check("first_sel", osel_a, 0);
    check("first_data", odata_a, 32'h10);
    check("first_valid", ovalid_a, 1);
    check("first_last", olast_a, 1);

    valid_a = 8'h00;
    #1;
    check("idle_ready", ordy_a, 0);
    tick();
    check("drain_valid", ovalid_a, 0);

    // Round-robin between channels 2 and 5 (pointer starts at 1).
    for (int i = 0; i < 6; i++) begin
      g = (i % 2 == 0) ? 2 : 5;
      valid_a = 8'h24;
      data_a[16 +: 8] = 8'(8'h20 + cnt2);
      data_a[40 +: 8] = 8'(8'h50 + cnt5);
      exp_d = (g == 2) ? 8'(8'h20 + cnt2) : 8'(8'h50 + cnt5);
      #1;
      check("rr_ready", ordy_a, 32'(1) << g);
      tick();
      $display("rr word %0d: sel=%0d data=%02h valid=%0b", i, osel_a, odata_a, ovalid_a);
      check("rr_sel", osel_a, g);
      check("rr_data", odata_a, exp_d);
      check("rr_valid", ovalid_a, 1);
      if (g == 2) cnt2++;
      else cnt5++;
    end
    valid_a = 8'h00;
    tick();
    check("rr_drain", ovalid_a, 0);

    // Single word on channel 0 moves the pointer to 1.
    valid_a = 8'h01;
    last_a  = 8'h01;
    data_a[0 +: 8] = 8'h0F;
    #1;
    check("pre_ready", ordy_a, 32'h01);
    tick();
    check("pre_data", odata_a, 32'h0F);

    // Channel 1 packet A0..A3 with channel 0 requesting throughout.
    valid_a = 8'h03;
    data_a[0 +: 8] = 8'h01;
    data_a[8 +: 8] = 8'hA0;
    #1;
    check("lock_ready0", ordy_a, 32'h02);
    tick();
    $display("lock word: sel=%0d data=%02h last=%0b", osel_a, odata_a, olast_a);
    check("lock_data0", odata_a, 32'hA0);
    check("lock_sel0", osel_a, 1);
    data_a[8 +: 8] = 8'hA1;
    #1;
    check("lock_ready1", ordy_a, 32'h02);
    tick();
    check("lock_data1", odata_a, 32'hA1);
    check("lock_last1", olast_a, 0);

    // Backpressure for three cycles mid-packet.
    ready_a = 1'b0;
    data_a[8 +: 8] = 8'hA2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", ordy_a, 0);
      tick();
      $display("backpressure %0d: sel=%0d data=%02h valid=%0b", i, osel_a, odata_a, ovalid_a);
      check("bp_data", odata_a, 32'hA1);
      check("bp_valid", ovalid_a, 1);
      check("bp_sel", osel_a, 1);
    end
    ready_a = 1'b1;
    #1;
    check("lock_ready2", ordy_a, 32'h02);
    tick();
    check("lock_data2", odata_a, 32'hA2);
    data_a[8 +: 8] = 8'hA3;
    last_a = 8'h03;
    #1;
    check("lock_ready3", ordy_a, 32'h02);
    tick();
    check("lock_data3", odata_a, 32'hA3);
    check("lock_last3", olast_a, 1);

    // Channel 0 next, then channel 2 beats channel 0 from pointer 1.
    valid_a = 8'h01;
    #1;
    check("post_ready0", ordy_a, 32'h01);
    tick();
    $display("after lock: sel=%0d data=%02h", osel_a, odata_a);
    check("post_sel0", osel_a, 0);
    check("post_data0", odata_a, 32'h01);
    valid_a = 8'h05;
    last_a  = 8'h05;
    data_a[16 +: 8] = 8'h22;
    #1;
    check("post_ready2", ordy_a, 32'h04);
    tick();
    check("post_sel2", osel_a, 2);
    check("post_data2", odata_a, 32'h22);
    valid_a = 8'h00;
    tick();

    check("sb_count", acc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc.size()) begin
        $display("scoreboard %0d: %02h", i, acc[i]);
        check("sb_word", acc[i], 8'(8'hA0 + i));
      end
    end

    // Reset in the middle of a 5-word packet on channel 4.
    valid_a = 8'h10;
    last_a  = 8'h00;
    data_a[32 +: 8] = 8'h40;
    #1;
    check("mid_ready", ordy_a, 32'h10);
    tick();
    check("mid_data0", odata_a, 32'h40);
    data_a[32 +: 8] = 8'h41;
    tick();
    check("mid_data1", odata_a, 32'h41);
    rst_n_a = 1'b0;
    data_a[32 +: 8] = 8'h42;
    #1;
    check("mid_rst_ready", ordy_a, 0);
    tick();
    $display("mid-packet reset: valid=%0b data=%02h sel=%0d last=%0b", ovalid_a, odata_a, osel_a, olast_a);
    check("mid_rst_valid", ovalid_a, 0);
    check("mid_rst_data", odata_a, 0);
    check("mid_rst_sel", osel_a, 0);
    check("mid_rst_last", olast_a, 0);
    rst_n_a = 1'b1;
    valid_a = 8'h80;
    data_a[56 +: 8] = 8'h77;
    #1;
    check("post_rst_ready", ordy_a, 32'h80);
    tick();
    check("post_rst_sel", osel_a, 7);
    check("post_rst_data", odata_a, 32'h77);
    check("post_rst_valid", ovalid_a, 1);
    valid_a = 8'h00;

    // Fixed priority with masking on the second instance.
    valid_b = 8'h48;
    mask_b  = 8'hF7;
    last_b  = 8'h08;
    data_b[24 +: 8] = 8'h30;
    data_b[48 +: 8] = 8'h60;
    #1;
    check("fp_ready_masked", ordy_b, 32'h40);
    tick();
    $display("fixed prio: sel=%0d data=%02h", osel_b, odata_b);
    check("fp_sel6", osel_b, 6);
    check("fp_data60", odata_b, 32'h60);
    mask_b = 8'hBF;
    data_b[48 +: 8] = 8'h61;
    #1;
    check("fp_lock_ready1", ordy_b, 32'h40);
    tick();
    check("fp_data61", odata_b, 32'h61);
    data_b[48 +: 8] = 8'h62;
    last_b = 8'h48;
    #1;
    check("fp_lock_ready2", ordy_b, 32'h40);
    tick();
    check("fp_data62", odata_b, 32'h62);
    check("fp_last62", olast_b, 1);
    mask_b = 8'hFF;
    last_b = 8'h08;
    #1;
    check("fp_ready3", ordy_b, 32'h08);
    tick();
    $display("fixed prio: sel=%0d data=%02h", osel_b, odata_b);
    check("fp_sel3", osel_b, 3);
    check("fp_data30", odata_b, 32'h30);
    data_b[24 +: 8] = 8'h31;
    #1;
    check("fp_ready3b", ordy_b, 32'h08);
    tick();
    check("fp_sel3b", osel_b, 3);
    check("fp_data31", odata_b, 32'h31);
    valid_b = 8'h00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
